// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared widths, defaults and state encoding for the hazard controller
package pipeline_hazard_controller_pkg;
   localparam int INSTRUCTION_LEN  = 32;
   localparam int ADDRESS_LEN      = 32;
   localparam int REG_ADDR_LEN     = 5;
   localparam int DEF_LOAD_LATENCY = 1;
   localparam int DEF_MEM_TIMEOUT  = 255;
   localparam int DEF_CNT_W        = 32;
   typedef enum logic [1:0] {RUN, LOAD_STALL, HALT} state_e;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;
   always_comb q_d = clr ? '0 : (inc & ~&q_q) ? q_q + W'(1) : q_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end
   assign q = q_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/bubble sequencer for the 5-stage pipeline
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_LEN,
   parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
   parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write_en,
   output logic                  if_id_write_en,
   output logic                  id_ex_write_en,
   output logic                  ex_mem_write_en,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  mem_wb_bubble,
   output logic                  halted,
   output logic                  mem_timeout_err,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);
   localparam int LW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY + 1) : 1;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   state_e        state_q, state_d;
   logic [LW-1:0] ld_cnt_q, ld_cnt_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic          err_q, err_d;
   logic          mem_stall, load_use, halt, freeze, branch, ld_stall, timeout;
   logic          stall_inc, flush_inc;
   always_comb begin
      mem_stall       = dmem_req & ~dmem_ready;
      load_use        = ex_mem_read & (ex_rd != '0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      halt            = state_q == HALT;
      freeze          = ~halt & mem_stall;
      // a taken branch makes the ID instruction wrong-path, so it beats any load-use stall
      branch          = ~halt & ~mem_stall & ex_branch_taken;
      ld_stall        = ~halt & ~mem_stall & ~ex_branch_taken & ((state_q == LOAD_STALL) | load_use);
      timeout         = freeze & (wait_cnt_q == WW'(MEM_TIMEOUT - 1));
      pc_write_en     = ~rst & ~halt & ~freeze & ~ld_stall;
      if_id_write_en  = ~rst & ~halt & ~freeze & ~ld_stall;
      id_ex_write_en  = ~rst & ~halt & ~freeze;
      ex_mem_write_en = ~rst & ~halt & ~freeze;
      if_id_flush     = ~rst & branch;
      id_ex_bubble    = ~rst & (branch | ld_stall);
      mem_wb_bubble   = ~rst & freeze;
      halted          = ~rst & halt;
      mem_timeout_err = err_q;
      stall_inc       = ~rst & ~halt & ~pc_write_en;
      flush_inc       = ~rst & branch;
      wait_cnt_d      = freeze ? wait_cnt_q + WW'(1) : '0;
      err_d           = err_q | timeout;
      state_d         = timeout ? HALT :
                        (halt | freeze) ? state_q :
                        branch ? RUN :
                        (state_q == LOAD_STALL) ? ((ld_cnt_q == LW'(1)) ? RUN : LOAD_STALL) :
                        (load_use & (LOAD_LATENCY > 1)) ? LOAD_STALL : RUN;
      ld_cnt_d        = (halt | freeze | branch) ? ld_cnt_q :
                        (state_q == LOAD_STALL) ? ld_cnt_q - LW'(1) :
                        load_use ? LW'(LOAD_LATENCY - 1) : ld_cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         ld_cnt_q   <= '0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (stall_inc),
      .q   (stall_cycles)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (flush_inc),
      .q   (flush_count)
   );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: two controller instances (load latency 1 and 3) against a cycle-level reference model
module tb_pipeline_hazard_controller;
   localparam int CW = 32;
   localparam int MT = 8;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
   logic [8:0]    ctl [2];
   logic [CW-1:0] stc [2];
   logic [CW-1:0] flc [2];
   int errors = 0;
   int checks = 0;
   int     m_halt [2], m_err [2], m_left [2], m_wait [2];
   longint m_stall [2], m_flush [2];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic pc, ifid, idex, exmem, fl, idb, mwb, hl, er;
      logic [CW-1:0] sc, fc;
      pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(g == 0 ? 1 : 3), .MEM_TIMEOUT(MT), .CNT_W(CW)) u_dut (
         .clk             (clk),
         .rst             (rst),
         .id_rs1          (id_rs1),
         .id_rs2          (id_rs2),
         .id_uses_rs1     (id_uses_rs1),
         .id_uses_rs2     (id_uses_rs2),
         .ex_mem_read     (ex_mem_read),
         .ex_rd           (ex_rd),
         .ex_branch_taken (ex_branch_taken),
         .dmem_req        (dmem_req),
         .dmem_ready      (dmem_ready),
         .pc_write_en     (pc),
         .if_id_write_en  (ifid),
         .id_ex_write_en  (idex),
         .ex_mem_write_en (exmem),
         .if_id_flush     (fl),
         .id_ex_bubble    (idb),
         .mem_wb_bubble   (mwb),
         .halted          (hl),
         .mem_timeout_err (er),
         .stall_cycles    (sc),
         .flush_count     (fc)
      );
      assign ctl[g] = {pc, ifid, idex, exmem, fl, idb, mwb, hl, er};
      assign stc[g] = sc;
      assign flc[g] = fc;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic longint sat_add(input longint v);
      return (v < 64'hFFFF_FFFF) ? v + 1 : v;
   endfunction
   // One cycle of the pipeline rules; returns the outputs expected during this cycle.
   task automatic model_step(input int i, input int ll, output logic [8:0] e);
      bit ms, lu, pc, ifid, idex, exmem, fl, idb, mwb, nh;
      ms = dmem_req && !dmem_ready;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      {pc, ifid, idex, exmem, fl, idb, mwb} = '0;
      nh = m_halt[i] != 0;
      if (m_halt[i] == 0) begin
         if (ms) begin
            mwb = 1;
            m_wait[i]++;
            m_stall[i] = sat_add(m_stall[i]);
            if (m_wait[i] == MT) nh = 1;
         end else begin
            m_wait[i] = 0;
            {pc, ifid, idex, exmem} = 4'hF;
            if (ex_branch_taken) begin
               fl = 1;
               idb = 1;
               m_left[i] = 0;
               m_flush[i] = sat_add(m_flush[i]);
            end else if (m_left[i] > 0 || lu) begin
               if (m_left[i] == 0) m_left[i] = ll;
               m_left[i]--;
               pc = 0;
               ifid = 0;
               idb = 1;
               m_stall[i] = sat_add(m_stall[i]);
            end
         end
      end
      e = {pc, ifid, idex, exmem, fl, idb, mwb, m_halt[i] != 0, m_err[i] != 0};
      if (nh && m_halt[i] == 0) begin
         m_halt[i] = 1;
         m_err[i] = 1;
      end
   endtask
   task automatic step(input string tag);
      logic [8:0] e;
      #3;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/u%0d/stall_cycles", tag, i), stc[i], m_stall[i]);
         check($sformatf("%s/u%0d/flush_count", tag, i), flc[i], m_flush[i]);
         model_step(i, i == 0 ? 1 : 3, e);
         check($sformatf("%s/u%0d/ctl", tag, i), ctl[i], e);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/u%0d/rst_ctl", tag, i), ctl[i], 9'h0);
         check($sformatf("%s/u%0d/rst_stall", tag, i), stc[i], 0);
         check($sformatf("%s/u%0d/rst_flush", tag, i), flc[i], 0);
         m_halt[i] = 0; m_err[i] = 0; m_left[i] = 0; m_wait[i] = 0;
         m_stall[i] = 0; m_flush[i] = 0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   task automatic set_in(input int r1, input bit u1, input int r2, input bit u2,
                         input bit mr, input int rd, input bit br, input bit req, input bit rdy);
      id_rs1 = 5'(r1); id_uses_rs1 = u1; id_rs2 = 5'(r2); id_uses_rs2 = u2;
      ex_mem_read = mr; ex_rd = 5'(rd); ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
   endtask
   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      do_reset("init");
      step("idle");
      set_in(3, 1, 0, 0, 1, 3, 0, 0, 0);
      step("lu1");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("lu1_clr");
      check("t1_stall_cycles", stc[0], 1);
      do_reset("t2");
      set_in(3, 1, 0, 0, 1, 3, 0, 0, 0);
      step("lu3");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step("lu3_tail");
      check("t2_stall_cycles", stc[1], 3);
      set_in(0, 1, 0, 1, 1, 0, 0, 0, 0);
      step("rd0");
      do_reset("t3");
      set_in(3, 1, 3, 1, 1, 3, 1, 0, 0);
      step("br_lu");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("br_after");
      check("t3_flush_count", flc[0], 1);
      check("t3_stall_cycles", stc[0], 0);
      do_reset("t4");
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (4) step("mwait");
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("mready");
      set_in(0, 0, 7, 1, 1, 7, 0, 0, 0);
      step("lu_then_wait");
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
      repeat (2) step("wait_in_stall");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step("stall_resume");
      do_reset("t5");
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (MT + 2) step("wdog");
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      repeat (3) step("halted");
      check("t5_halted", ctl[0][1:0], 2'b11);
      check("t5_stall_frozen", stc[1], MT);
      do_reset("t6_halt");
      set_in(5, 1, 0, 0, 1, 5, 0, 0, 0);
      step("lu_pre_rst");
      do_reset("t6_ldstall");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("post_rst");
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
         set_in($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         step("rnd");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Generates write enables, flushes and bubbles for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes: load-use, taken branch resolved in EX, and data-memory wait.
- Adds a memory watchdog that halts the pipeline, plus saturating performance counters.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- LOAD_LATENCY, 1, stall cycles per load-use hazard; must be ≥1.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before halt.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  source-operand valid flags.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_branch_taken  in  1  taken branch or jump resolved in EX.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1  register load enables.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP into ID/EX.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- halted  out  1  pipeline halted (state HALT).
- mem_timeout_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  cycles with pc_write_en=0, excluding HALT.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:
- Control outputs are combinational from state, counters and inputs. State and counters are registered.
- Default output values: all write_en=1; flush and bubble outputs 0.
- While rst=1: all write_en=0; flush/bubble=0; state RUN; all counters 0; mem_timeout_err=0.
- Derived signals:
  - mem_stall = dmem_req & ~dmem_ready.
  - load_use = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority, evaluated every cycle: HALT > mem_stall > ex_branch_taken > load_use/LOAD_STALL.
- mem_stall (any non-HALT state): full freeze.
  - All four write_en=0; mem_wb_bubble=1.
  - State and load counter hold.
  - wait_cnt increments. wait_cnt resets to 0 on any cycle without mem_stall.
- Watchdog: when mem_stall and wait_cnt==MEM_TIMEOUT-1, next state is HALT and mem_timeout_err is set. Both persist until rst.
- State RUN:
  - ex_branch_taken: pc_write_en=1 (target load); if_id_flush=1; id_ex_bubble=1; flush_count+1; stay RUN. This overrides load_use, since the ID instruction is wrong-path.
  - load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
    - LOAD_LATENCY==1: stay RUN.
    - Otherwise: load ld_cnt=LOAD_LATENCY-1 and go to LOAD_STALL.
  - Else: all enables 1.
- State LOAD_STALL:
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; ld_cnt decrements.
  - Go to RUN in the cycle ld_cnt==1 is consumed.
  - ex_branch_taken in this state: branch response as in RUN; abort the stall; go to RUN.
- State HALT: all write_en=0, bubbles 0, halted=1. Exit only by rst.
- Counters saturate at all-ones; no wrap.
- stall_cycles increments on each non-reset, non-HALT cycle with pc_write_en=0.
- A rst assertion mid-stall or in HALT returns immediately to the reset values.

Decomposition:
- Shared package holds the state enum (RUN, LOAD_STALL, HALT) and the default parameter constants.
- REG_ADDR_W follows the existing shared defines alongside INSTRUCTION_LEN and ADDRESS_LEN.
- One natural sub-module: sat_counter (parameterised width, inc, clear, saturation). Instantiated for stall_cycles and flush_count.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_uses_rs1=1, LOAD_LATENCY=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle (hazard cleared) all enables 1; stall_cycles=1.
2. LOAD_LATENCY=3, same hazard -> 3 consecutive stall cycles, then RUN; stall_cycles=3. ex_rd=0 with the same operands -> no stall.
3. Branch plus simultaneous load_use -> pc_we=1, if_id_flush=1, id_ex_bubble=1, no stall; flush_count=1.
4. dmem_req=1, dmem_ready=0 for 4 cycles, then ready -> 4 freeze cycles with mem_wb_bubble=1; then normal flow; LOAD_STALL counter preserved if the wait happens inside a stall.
5. MEM_TIMEOUT=8, dmem_ready held 0 -> after 8 cycles halted=1 and mem_timeout_err=1; enables stay 0 when dmem_ready rises; stall_cycles frozen.
6. rst pulsed during LOAD_STALL and during HALT -> outputs are reset values immediately; after release all enables 1 and counters 0.
